// File: rtl/segment_pattern_reader_pkg.sv
// Shared 7-segment encoding table (active-low, bit0=a .. bit6=g) and the
// state encoding used by the segment pattern reader.
package segment_pattern_reader_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [0:0] ST_STABLE   = 1'b0;
   localparam logic [0:0] ST_SETTLING = 1'b1;

   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

   // Drive-side helper so the level-to-segment decoder shares this exact table.
   function automatic logic [6:0] seg_of_digit(input logic [3:0] i_D);
      logic [6:0] v_Seg;
      case (i_D)
         4'd0:    v_Seg = SEG_0;
         4'd1:    v_Seg = SEG_1;
         4'd2:    v_Seg = SEG_2;
         4'd3:    v_Seg = SEG_3;
         4'd4:    v_Seg = SEG_4;
         4'd5:    v_Seg = SEG_5;
         4'd6:    v_Seg = SEG_6;
         4'd7:    v_Seg = SEG_7;
         4'd8:    v_Seg = SEG_8;
         4'd9:    v_Seg = SEG_9;
         default: v_Seg = SEG_BLANK;
      endcase
      return v_Seg;
   endfunction

endpackage

// File: rtl/segment_pattern_reader_classifier.sv
// Combinational decode of an active-low 7-segment pattern into a BCD digit,
// with flags for a legal digit and for the all-off blank pattern.
module segment_pattern_classifier
   import segment_pattern_reader_pkg::*;
(
   input  logic [6:0] i_Pattern,
   output logic [3:0] o_Digit,
   output logic       o_Is_Digit,
   output logic       o_Is_Blank
);

   always_comb begin
      o_Digit    = 4'd0;
      o_Is_Digit = 1'b1;
      o_Is_Blank = 1'b0;
      case (i_Pattern)
         SEG_0:     o_Digit = 4'd0;
         SEG_1:     o_Digit = 4'd1;
         SEG_2:     o_Digit = 4'd2;
         SEG_3:     o_Digit = 4'd3;
         SEG_4:     o_Digit = 4'd4;
         SEG_5:     o_Digit = 4'd5;
         SEG_6:     o_Digit = 4'd6;
         SEG_7:     o_Digit = 4'd7;
         SEG_8:     o_Digit = 4'd8;
         SEG_9:     o_Digit = 4'd9;
         SEG_BLANK: begin
            o_Is_Digit = 1'b0;
            o_Is_Blank = 1'b1;
         end
         default:   o_Is_Digit = 1'b0;
      endcase
   end

endmodule

// File: rtl/segment_pattern_reader.sv
// Monitors a 7-segment drive bus, waits for the pattern to hold steady for
// STABLE_CYCLES samples, then reports the digit, blank or illegal pattern.
module segment_pattern_reader
   import segment_pattern_reader_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
)
(
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic [6:0] i_Segment,
   output logic [3:0] o_Digit,
   output logic       o_Valid,
   output logic       o_Blank,
   output logic       o_Error,
   output logic       o_Busy,
   output logic [7:0] o_Error_Count
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [6:0]       r_Seg;
   logic [CNT_W-1:0] r_Cnt;
   logic [0:0]       r_State;
   logic [3:0]       r_Digit;
   logic             r_Valid;
   logic             r_Blank;
   logic             r_Error;
   logic [7:0]       r_Err_Cnt;

   logic [3:0]       w_Class_Digit;
   logic             w_Is_Digit;
   logic             w_Is_Blank;
   logic             w_Changed;
   logic             w_Done;

   segment_pattern_classifier u_classifier (
      .i_Pattern  (r_Seg),
      .o_Digit    (w_Class_Digit),
      .o_Is_Digit (w_Is_Digit),
      .o_Is_Blank (w_Is_Blank)
   );

   assign w_Changed = (i_Segment != r_Seg);
   assign w_Done    = (r_State == ST_SETTLING) && (r_Cnt == LP_LAST);

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_Seg     <= SEG_BLANK;
         r_Cnt     <= '0;
         r_State   <= ST_STABLE;
         r_Digit   <= 4'd0;
         r_Valid   <= 1'b0;
         r_Blank   <= 1'b1;
         r_Error   <= 1'b0;
         r_Err_Cnt <= 8'd0;
      end else begin
         r_Seg   <= i_Segment;
         r_Valid <= 1'b0;
         // A fresh change always restarts settling, even on the final count.
         if (w_Changed) begin
            r_Cnt   <= '0;
            r_State <= ST_SETTLING;
         end else if (w_Done) begin
            r_State <= ST_STABLE;
            if (w_Is_Digit) begin
               r_Digit <= w_Class_Digit;
               r_Valid <= 1'b1;
               r_Blank <= 1'b0;
               r_Error <= 1'b0;
            end else if (w_Is_Blank) begin
               r_Blank <= 1'b1;
               r_Error <= 1'b0;
            end else begin
               r_Blank <= 1'b0;
               r_Error <= 1'b1;
               if (r_Err_Cnt != ERR_CNT_MAX) begin
                  r_Err_Cnt <= r_Err_Cnt + 8'd1;
               end
            end
         end else if (r_State == ST_SETTLING) begin
            r_Cnt <= r_Cnt + 1'b1;
         end
      end
   end

   assign o_Digit       = r_Digit;
   assign o_Valid       = r_Valid;
   assign o_Blank       = r_Blank;
   assign o_Error       = r_Error;
   assign o_Busy        = (r_State == ST_SETTLING);
   assign o_Error_Count = r_Err_Cnt;

endmodule
